// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Elastic IF/ID pipeline stage. A DEPTH-entry circular buffer of
//   {pc, instr} pairs sits between fetch and decode. Both sides use
//   valid/ready handshakes. Decode stalls do not force a refetch. A flush
//   discards every entry and presents a NOP to decode in the same cycle.
//
// Parameters
//   XLEN      : pc width
//   ILEN      : instruction width
//   DEPTH     : number of entries, power of two, 2..16
//   NOP_INSTR : instruction shown to decode when no valid entry exists
//
// Ports
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   pc, instr : fetch-side entry
//   if_valid  : fetch entry valid
//   if_ready  : queue has room (depends only on registered state)
//   flush     : synchronous discard of all entries; priority over push/pop
//   id_ready  : decode consumes the head entry this cycle
//   id_valid  : head entry valid (masked by flush)
//   pc_ID     : head pc, 0 when empty
//   instr_ID  : head instruction, NOP_INSTR when empty or flushing
//   stall_cnt : cycles with id_valid & !id_ready; this port exists only
//               when IF_ID_STALL_CNT_EN is defined
//
// Build option
//   IF_ID_STALL_CNT_EN : adds the stall_cnt output and its counter
// ---------------------------------------------------------------------------
module if_id_queue #(
   parameter int              XLEN      = 32,
   parameter int              ILEN      = 32,
   parameter int              DEPTH     = 2,
   parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic [ILEN-1:0] instr,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic            flush,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] pc_ID,
   output logic [ILEN-1:0] instr_ID
`ifdef IF_ID_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } occ_e;

   occ_e            occ_q, occ_d;
   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] pc_mem_d    [DEPTH];
   logic [ILEN-1:0] instr_mem_q [DEPTH];
   logic [ILEN-1:0] instr_mem_d [DEPTH];

   logic has_entry;
   logic push;
   logic pop;

   // Both handshake outputs come from the registered occupancy state, so
   // if_ready never depends on id_ready: a pop while full frees the slot
   // only for the following cycle.
   assign has_entry = (occ_q != ST_EMPTY);
   assign if_ready  = (occ_q != ST_FULL);
   assign id_valid  = has_entry & ~flush;
   assign push      = if_valid & if_ready & ~flush;
   assign pop       = id_valid & id_ready;

   assign pc_ID    = has_entry ? pc_mem_q[rp_q] : '0;
   assign instr_ID = (has_entry & ~flush) ? instr_mem_q[rp_q] : NOP_INSTR;

   // Pointer, count and storage update
   always_comb begin
      wp_d        = wp_q;
      rp_d        = rp_q;
      count_d     = count_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      if (flush) begin
         // Stale entry contents are left in place. They are unreachable
         // once count is zero.
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) begin
            pc_mem_d[wp_q]    = pc;
            instr_mem_d[wp_q] = instr;
            wp_d              = wp_q + AW'(1);
         end
         if (pop) begin
            rp_d = rp_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Occupancy FSM next state. It tracks the count and is reset to EMPTY
   // by a flush from any state.
   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = ST_EMPTY;
      end else begin
         case (occ_q)
            ST_EMPTY: begin
               if (push) occ_d = (FULL_CNT == CW'(1)) ? ST_FULL : ST_PARTIAL;
            end
            ST_PARTIAL: begin
               if (push && !pop && (count_q == FULL_CNT - CW'(1)))
                  occ_d = ST_FULL;
               else if (pop && !push && (count_q == CW'(1)))
                  occ_d = ST_EMPTY;
            end
            ST_FULL: begin
               // No push is possible while full; a pop leaves DEPTH-1.
               if (pop) occ_d = (FULL_CNT == CW'(1)) ? ST_EMPTY : ST_PARTIAL;
            end
            default: occ_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q   <= ST_EMPTY;
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         occ_q       <= occ_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         count_q     <= count_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

`ifdef IF_ID_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Counts decode back-pressure cycles. It wraps freely and only reset
   // clears it, so it survives a redirect.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (id_valid && !id_ready) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
